// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: FSM state encoding,
// report frame layout and the frame byte selector.
package freq_meter_pkg;

    localparam int unsigned CNT_W     = 32;
    localparam int unsigned FRAME_LEN = 6;
    localparam logic [7:0]  FRAME_HDR = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StGate,
        StSettle,
        StLatch,
        StSend
    } state_e;

    // Byte idx of the report frame for a given count: header, count MSB..LSB, XOR check.
    function automatic logic [7:0] frame_byte(input logic [CNT_W-1:0] count,
                                              input logic [2:0]       idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = FRAME_HDR;
            3'd1:    b = count[31:24];
            3'd2:    b = count[23:16];
            3'd3:    b = count[15:8];
            3'd4:    b = count[7:0];
            3'd5:    b = count[31:24] ^ count[23:16] ^ count[15:8] ^ count[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/freq_meas_sequencer_if.sv
// Edge-counter control and UART TX byte handshake between the measurement
// sequencer (master) and its counter/transmitter peers (slave).
interface freq_meas_sequencer_if;
    import freq_meter_pkg::*;

    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_val;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (
        output cnt_clr, cnt_en, tx_data, tx_valid,
        input  cnt_val, tx_ready
    );

    modport slave (
        input  cnt_clr, cnt_en, tx_data, tx_valid,
        output cnt_val, tx_ready
    );

endinterface

// File: rtl/freq_meas_sequencer_report_framer.sv
// Holds the latched count and streams the 6-byte report frame over a
// valid/ready byte port; last_o flags the transfer of the final byte.
module report_framer
    import freq_meter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             last_o
);

    localparam logic [2:0] LastIdx = 3'(FRAME_LEN - 1);

    logic [CNT_W-1:0] count_q;
    logic [2:0]       idx_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             xfer;

    assign xfer = valid_q & tx_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            count_q <= count_i;
            idx_q   <= '0;
            data_q  <= FRAME_HDR;
            valid_q <= 1'b1;
        end else if (xfer) begin
            if (idx_q == LastIdx) begin
                valid_q <= 1'b0;
            end else begin
                idx_q  <= idx_q + 3'd1;
                data_q <= frame_byte(count_q, idx_q + 3'd1);
            end
        end
    end

    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;
    assign last_o     = xfer && (idx_q == LastIdx);

endmodule

// File: rtl/freq_meas_sequencer.sv
// Gate-window measurement sequencer: clear, gate, settle and latch the edge
// counter, then hand the latched count to the report framer.
module freq_meas_sequencer
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 50_000_000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter bit          AUTO_RESTART  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    freq_meas_sequencer_if.master bus_io,
    output logic [CNT_W-1:0]      freq_hz_o,
    output logic                  meas_done_o,
    output logic                  busy_o
);

    localparam logic [CNT_W-1:0] GateLast   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [7:0]       SettleLast = 8'(SETTLE_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] gate_cnt_q;
    logic [7:0]       settle_cnt_q;
    logic             cnt_clr_q;
    logic             cnt_en_q;
    logic [CNT_W-1:0] freq_q;
    logic             done_q;
    logic             busy_q;
    logic             frame_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            gate_cnt_q   <= '0;
            settle_cnt_q <= '0;
            cnt_clr_q    <= 1'b0;
            cnt_en_q     <= 1'b0;
            freq_q       <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StClear;
                        cnt_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StClear: begin
                    state_q    <= StGate;
                    cnt_en_q   <= 1'b1;
                    gate_cnt_q <= '0;
                end
                StGate: begin
                    if (gate_cnt_q == GateLast) begin
                        state_q      <= StSettle;
                        cnt_en_q     <= 1'b0;
                        settle_cnt_q <= '0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + 1'b1;
                    end
                end
                StSettle: begin
                    // Count is sampled here so freq_hz and meas_done land together.
                    if (settle_cnt_q == SettleLast) begin
                        state_q <= StLatch;
                        freq_q  <= bus_io.cnt_val;
                        done_q  <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                StLatch: begin
                    state_q <= StSend;
                end
                StSend: begin
                    if (frame_last) begin
                        if (AUTO_RESTART) begin
                            state_q   <= StClear;
                            cnt_clr_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    report_framer u_framer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == StLatch),
        .count_i    (freq_q),
        .tx_data_o  (bus_io.tx_data),
        .tx_valid_o (bus_io.tx_valid),
        .tx_ready_i (bus_io.tx_ready),
        .last_o     (frame_last)
    );

    assign bus_io.cnt_clr = cnt_clr_q;
    assign bus_io.cnt_en  = cnt_en_q;
    assign freq_hz_o      = freq_q;
    assign meas_done_o    = done_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Bench for freq_meas_sequencer: two instances (single-shot and auto-restart)
// against a timeline model of one measurement cycle.
module tb_freq_meas_sequencer;

    localparam int G0 = 100;
    localparam int S0 = 4;
    localparam int G1 = 20;
    localparam int S1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  start;
    logic [1:0]  ready;
    logic [31:0] fval [2];
    logic [1:0]  fmode;
    int          rmode [2];
    int          stall_base;
    int          cyc;

    logic [1:0]  d_clr, d_en, d_valid, d_busy, d_done;
    logic [7:0]  d_data [2];
    logic [31:0] d_freq [2];
    logic [31:0] cval [2];

    logic [31:0] ec [2];
    logic [1:0]  div [2];

    freq_meas_sequencer_if if0 ();
    freq_meas_sequencer_if if1 ();

    freq_meas_sequencer #(.GATE_CYCLES(G0), .SETTLE_CYCLES(S0), .AUTO_RESTART(1'b0)) u_dut0 (
        .clk         (clk),
        .rst         (rst[0]),
        .start_i     (start[0]),
        .bus_io      (if0),
        .freq_hz_o   (d_freq[0]),
        .meas_done_o (d_done[0]),
        .busy_o      (d_busy[0])
    );

    freq_meas_sequencer #(.GATE_CYCLES(G1), .SETTLE_CYCLES(S1), .AUTO_RESTART(1'b1)) u_dut1 (
        .clk         (clk),
        .rst         (rst[1]),
        .start_i     (start[1]),
        .bus_io      (if1),
        .freq_hz_o   (d_freq[1]),
        .meas_done_o (d_done[1]),
        .busy_o      (d_busy[1])
    );

    assign d_clr[0]   = if0.cnt_clr;
    assign d_clr[1]   = if1.cnt_clr;
    assign d_en[0]    = if0.cnt_en;
    assign d_en[1]    = if1.cnt_en;
    assign d_valid[0] = if0.tx_valid;
    assign d_valid[1] = if1.tx_valid;
    assign d_data[0]  = if0.tx_data;
    assign d_data[1]  = if1.tx_data;
    assign cval[0]    = fmode[0] ? fval[0] : ec[0];
    assign cval[1]    = fmode[1] ? fval[1] : ec[1];
    assign if0.cnt_val  = cval[0];
    assign if1.cnt_val  = cval[1];
    assign if0.tx_ready = ready[0];
    assign if1.tx_ready = ready[1];

    // External edge counter: one test-clock edge every 4 system clocks while gated.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (d_clr[k]) begin
                ec[k]  <= 32'd0;
                div[k] <= 2'd0;
            end else if (d_en[k]) begin
                div[k] <= div[k] + 2'd1;
                if (div[k] == 2'd3) ec[k] <= ec[k] + 32'd1;
            end
        end
    end

    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];

    // TX ready patterns: 0 always, 1 one-in-three, 2 random, 3 stall after 3 bytes.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            case (rmode[k])
                0:       ready[k] = 1'b1;
                1:       ready[k] = (cyc % 3 == 0);
                2:       ready[k] = 1'($urandom_range(0, 1));
                default: ready[k] = ((rx0.size() - stall_base) < 3);
            endcase
        end
    end

    // Timeline model: t counts cycles from the cnt_clr cycle of the current measurement.
    bit          m_act  [2];
    bit          m_send [2];
    int          m_t    [2];
    int          m_idx  [2];
    logic [31:0] m_freq [2];
    logic [7:0]  m_frame [2][6];

    function automatic int gate_of(input int k);
        return (k == 0) ? G0 : G1;
    endfunction

    function automatic int settle_of(input int k);
        return (k == 0) ? S0 : S1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                m_act[k]  = 1'b0;
                m_send[k] = 1'b0;
                m_freq[k] = 32'd0;
            end else if (!m_act[k]) begin
                if (start[k]) begin
                    m_act[k] = 1'b1;
                    m_t[k]   = 0;
                end
            end else if (m_send[k]) begin
                if (ready[k]) begin
                    if (m_idx[k] == 5) begin
                        m_send[k] = 1'b0;
                        if (k == 1) m_t[k] = 0;
                        else        m_act[k] = 1'b0;
                    end else begin
                        m_idx[k]++;
                    end
                end
            end else begin
                m_t[k]++;
                if (m_t[k] == gate_of(k) + settle_of(k) + 1) m_freq[k] = cval[k];
                if (m_t[k] == gate_of(k) + settle_of(k) + 2) begin
                    m_send[k]     = 1'b1;
                    m_idx[k]      = 0;
                    m_frame[k][0] = 8'hA5;
                    m_frame[k][1] = 8'(m_freq[k] >> 24);
                    m_frame[k][2] = 8'(m_freq[k] >> 16);
                    m_frame[k][3] = 8'(m_freq[k] >> 8);
                    m_frame[k][4] = 8'(m_freq[k]);
                    m_frame[k][5] = m_frame[k][1] ^ m_frame[k][2] ^ m_frame[k][3] ^ m_frame[k][4];
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s dut%0d at %0t: got %0h want %0h", name, k, $time, got, want);
        end
    endtask

    int en_cnt [2];
    int done_cnt [2];
    int fcnt [2];
    int frames [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit ph;
            ph = m_act[k] && !m_send[k];
            chk("cnt_clr", k, 32'(d_clr[k]), 32'(ph && m_t[k] == 0));
            chk("cnt_en", k, 32'(d_en[k]), 32'(ph && m_t[k] >= 1 && m_t[k] <= gate_of(k)));
            chk("meas_done", k, 32'(d_done[k]),
                32'(ph && m_t[k] == gate_of(k) + settle_of(k) + 1));
            chk("tx_valid", k, 32'(d_valid[k]), 32'(m_send[k]));
            chk("busy", k, 32'(d_busy[k]), 32'(m_act[k]));
            chk("freq_hz", k, d_freq[k], m_freq[k]);
            if (m_send[k]) chk("tx_data", k, 32'(d_data[k]), 32'(m_frame[k][m_idx[k]]));

            en_cnt[k]   += int'(d_en[k]);
            done_cnt[k] += int'(d_done[k]);
            if (d_valid[k] && ready[k]) begin
                if (k == 0) rx0.push_back(d_data[0]);
                else        rx1.push_back(d_data[1]);
                fcnt[k]++;
                if (fcnt[k] == 6) begin
                    frames[k]++;
                    fcnt[k] = 0;
                end
            end
            if (rst[k]) fcnt[k] = 0;
        end
    end

    task automatic pulse_start(input int k);
        @(posedge clk); #1 start[k] = 1'b1;
        @(posedge clk); #1 start[k] = 1'b0;
    endtask

    task automatic pulse_rst(input int k);
        @(posedge clk); #1 rst[k] = 1'b1;
        @(posedge clk); #1 rst[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (d_busy[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (d_busy[k]) begin
            total++;
            bad++;
            $display("FAIL wait_idle dut%0d: still busy after %0d cycles, want idle", k, budget);
        end
    endtask

    function automatic logic [7:0] rx_at(input int k, input int i);
        return (k == 0) ? rx0[i] : rx1[i];
    endfunction

    task automatic chk_frame(input string name, input int k, input int base,
                             input logic [47:0] exp);
        int sz;
        sz = (k == 0) ? rx0.size() : rx1.size();
        if (sz < base + 6) begin
            chk({name, "_len"}, k, 32'(sz - base), 32'd6);
        end else begin
            for (int i = 0; i < 6; i++)
                chk(name, k, 32'(rx_at(k, base + i)), 32'(exp[47-8*i -: 8]));
        end
    endtask

    task automatic chk_reset_state(input string name, input int k);
        chk({name, "_valid"}, k, 32'(d_valid[k]), 32'd0);
        chk({name, "_data"}, k, 32'(d_data[k]), 32'd0);
        chk({name, "_busy"}, k, 32'(d_busy[k]), 32'd0);
        chk({name, "_en"}, k, 32'(d_en[k]), 32'd0);
        chk({name, "_clr"}, k, 32'(d_clr[k]), 32'd0);
        chk({name, "_done"}, k, 32'(d_done[k]), 32'd0);
        chk({name, "_freq"}, k, d_freq[k], 32'd0);
    endtask

    initial begin
        int b_en, b_done, b_rx, n;
        bit do_rst, hold;
        rst        = 2'b11;
        start      = 2'b00;
        fmode      = 2'b00;
        fval[0]    = 32'd0;
        fval[1]    = 32'd0;
        rmode[0]   = 0;
        rmode[1]   = 2;
        stall_base = 0;
        cyc        = 0;
        repeat (3) @(posedge clk);
        #1 rst = 2'b00;
        @(negedge clk);
        chk_reset_state("reset", 0);
        chk_reset_state("reset", 1);

        // Auto-restart instance gets exactly one start for the whole run.
        pulse_start(1);

        // Counter-driven measurement, ready always high.
        b_en   = en_cnt[0];
        b_done = done_cnt[0];
        b_rx   = rx0.size();
        pulse_start(0);
        wait_idle(0, 400);
        chk("gate_len", 0, 32'(en_cnt[0] - b_en), 32'd100);
        chk("done_pulses", 0, 32'(done_cnt[0] - b_done), 32'd1);
        chk("freq_25", 0, d_freq[0], 32'd25);
        chk_frame("frame_25", 0, b_rx, 48'hA5_00_00_00_19_19);

        // Forced count, 1/3 ready duty, start held through the gate window.
        fmode[0] = 1'b1;
        fval[0]  = 32'h1234_5678;
        rmode[0] = 1;
        b_rx     = rx0.size();
        @(posedge clk); #1 start[0] = 1'b1;
        repeat (110) @(posedge clk);
        #1 start[0] = 1'b0;
        wait_idle(0, 400);
        chk("freq_forced", 0, d_freq[0], 32'h1234_5678);
        chk_frame("frame_forced", 0, b_rx, 48'hA5_12_34_56_78_08);
        repeat (10) @(negedge clk);
        chk("no_restart", 0, 32'(d_busy[0]), 32'd0);

        // Reset in the middle of the gate window.
        fmode[0] = 1'b0;
        rmode[0] = 0;
        pulse_start(0);
        repeat (50) @(posedge clk);
        pulse_rst(0);
        @(negedge clk);
        chk_reset_state("rst_gate", 0);
        repeat (20) @(negedge clk);

        // Reset while byte 3 is stalled.
        stall_base = rx0.size();
        rmode[0]   = 3;
        pulse_start(0);
        n = 0;
        while (!((rx0.size() - stall_base) == 3 && d_valid[0]) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached", 0, 32'(rx0.size() - stall_base), 32'd3);
        repeat (3) @(posedge clk);
        pulse_rst(0);
        @(negedge clk);
        chk_reset_state("rst_send", 0);
        repeat (20) @(negedge clk);
        rmode[0] = 0;

        // Random counts, ready patterns, held starts and resets.
        for (int r = 0; r < 10; r++) begin
            fmode[0] = 1'($urandom_range(0, 1));
            fval[0]  = $urandom;
            rmode[0] = 2;
            do_rst   = ($urandom_range(0, 2) == 0);
            hold     = 1'($urandom_range(0, 1));
            @(posedge clk); #1 start[0] = 1'b1;
            if (!hold) begin
                @(posedge clk); #1 start[0] = 1'b0;
            end
            if (do_rst) begin
                repeat ($urandom_range(1, 140)) @(posedge clk);
                #1 start[0] = 1'b0;
                rst[0] = 1'b1;
                @(posedge clk); #1 rst[0] = 1'b0;
            end else if (hold) begin
                repeat (60) @(posedge clk);
                #1 start[0] = 1'b0;
            end
            wait_idle(0, 800);
            repeat ($urandom_range(1, 5)) @(posedge clk);
        end

        chk_frame("auto_first", 1, 0, 48'hA5_00_00_00_05_05);
        chk("auto_frames", 1, 32'(frames[1] >= 3), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/freq_meas_sequencer.md
# freq_meas_sequencer

Measurement controller for the frequency meter. Sequences one gate-window measurement cycle: clears and enables the external edge counter for a fixed number of system clocks, waits for the counter's synchronizer pipeline to drain, and latches the count. It then streams a 6-byte report frame to the UART transmitter over a valid/ready byte interface. Sits between the top-level frequency-meter wrapper, the test-clock edge counter and the UART TX byte port.

## Interface
Parameters:
- GATE_CYCLES, 50_000_000, gate window length in clk cycles (1 s at 50 MHz); legal range 1..2^32-1
- SETTLE_CYCLES, 4, post-gate drain cycles for the counter synchronizer; legal range 1..255
- AUTO_RESTART, 1, 1 = start next measurement after frame sent; 0 = wait for start

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin measurement; sampled only in IDLE
- cnt_clr  out  1  one-cycle clear pulse to edge counter
- cnt_en  out  1  edge counter enable (gate)
- cnt_val  in  32  edge counter value
- tx_data  out  8  report byte
- tx_valid  out  1  byte valid
- tx_ready  in  1  UART TX accepts byte
- freq_hz  out  32  last latched count (Hz when gate = 1 s)
- meas_done  out  1  one-cycle pulse when freq_hz updates
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CLEAR, GATE, SETTLE, LATCH, SEND.
- IDLE: busy=0; start=1 -> CLEAR. After reset, an AUTO_RESTART=1 instance still waits for the first start.
- CLEAR: cnt_clr=1 for exactly 1 cycle -> GATE.
- GATE: cnt_en=1 for exactly GATE_CYCLES cycles (gate timer 32-bit, counts 0..GATE_CYCLES-1) -> SETTLE.
- SETTLE: cnt_en=0, wait SETTLE_CYCLES cycles -> LATCH.
- LATCH: freq_hz <= cnt_val, meas_done=1 for 1 cycle, build frame -> SEND.
- SEND: frame bytes in order: 0xA5, freq_hz[31:24], [23:16], [15:8], [7:0], XOR of the four count bytes. Byte index 0..5.
- After byte 5 accepted: AUTO_RESTART=1 -> CLEAR; else -> IDLE.
- start outside IDLE is ignored (not queued).
- cnt_val is not saturated or checked; wrap-around in the counter is reported as-is.

## Timing
- Reset values: cnt_clr=0, cnt_en=0, tx_valid=0, tx_data=0x00, freq_hz=0, meas_done=0, busy=0, state IDLE, timers 0.
- rst mid-operation returns to IDLE next edge. tx_valid drops immediately even if a byte is pending. freq_hz clears to 0.
- All outputs are registered.
- start high at edge N -> cnt_clr high cycle N+1 -> cnt_en high cycles N+2..N+1+GATE_CYCLES.
- LATCH occurs SETTLE_CYCLES cycles after cnt_en falls. meas_done coincides with freq_hz update.
- tx_valid asserts the cycle after LATCH. Byte transfer occurs on the edge where tx_valid & tx_ready.
- tx_data is stable while tx_valid=1 & tx_ready=0. tx_valid is never withdrawn without a transfer (except reset).
- Next byte is presented on the cycle after a transfer (back-to-back with tx_ready held high: 6 bytes in 6 cycles).
- tx_ready high before tx_valid has no effect.
- With AUTO_RESTART=1, cnt_clr pulses the cycle after the last transfer.

## Structure
- Shared package freq_meter_pkg: state encoding enum, FRAME_HDR=8'hA5, FRAME_LEN=6, CNT_W=32.
- One natural sub-module: report_framer (frame buffer + byte index + valid/ready handshake). Sequencer FSM and gate/settle timers stay in the top of this block.

## Test plan
- GATE_CYCLES=100, SETTLE=4; start pulse; counter model increments every 4 clk while cnt_en -> cnt_en high exactly 100 cycles, freq_hz=25, meas_done 1 pulse, frame A5 00 00 00 19 19.
- tx_ready held high -> 6 consecutive-cycle transfers; tx_ready toggled 1/3 duty -> same 6 bytes, tx_data stable during stalls.
- cnt_val forced 0x12345678 -> frame A5 12 34 56 78 08, freq_hz=0x12345678.
- AUTO_RESTART=1, start once -> second cnt_clr exactly 1 cycle after 6th transfer; three frames observed without further start.
- rst asserted mid-GATE and mid-SEND (byte 3 stalled) -> next cycle all outputs at reset values, state IDLE, no further tx_valid until start.
- start held high during GATE/SEND with AUTO_RESTART=0 -> ignored; returns to IDLE after frame, restarts only on start sampled in IDLE.
